// File: rtl/i2s_tx_if.sv
// i2s_tx_if: sample-pair handshake between a producer and the I2S transmitter
interface i2s_tx_if #(parameter int DATA_W = 24);
  logic [DATA_W-1:0] lft_in;
  logic [DATA_W-1:0] rht_in;
  logic vld;
  logic rdy;
  modport master (output lft_in, rht_in, vld, input rdy);
  modport slave (input lft_in, rht_in, vld, output rdy);
endinterface

// File: rtl/i2s_tx.sv
// i2s_tx: I2S transmitter with one-pair holding buffer and clk-derived codec clocks
module i2s_tx #(parameter int DATA_W = 24) (
  input  logic   clk,
  input  logic   rst,
  i2s_tx_if.slave bus,
  output logic   MCLK,
  output logic   SCLK,
  output logic   LRCLK,
  output logic   SDout,
  output logic   underrun
);
  logic [10:0] cnt, cnt_n;
  logic [4:0] slot;
  logic full, frame;
  logic [DATA_W-1:0] buf_l, buf_r, sh_l, sh_r, word, tx;
  assign cnt_n = cnt + 11'd1;
  assign frame = &cnt;
  assign slot = cnt_n[9:5];
  assign word = cnt_n[10] ? sh_r : sh_l;
  assign bus.rdy = ~full;
  assign {LRCLK, SCLK, MCLK} = {cnt[10], cnt[4], cnt[1]};
  // free-running counter, serial data advanced only as SCLK falls, underrun pulse at frame start
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      SDout <= 1'b0;
      tx <= '0;
      underrun <= 1'b0;
    end else begin
      cnt <= cnt_n;
      if (cnt_n[4:0] == 5'd0) begin
        SDout <= slot == 5'd1 ? word[DATA_W-1] :
                 (slot != 5'd0 && slot <= 5'(DATA_W)) ? tx[DATA_W-1] : 1'b0;
        tx <= slot == 5'd1 ? word << 1 : tx << 1;
      end
      underrun <= frame && !full && !bus.vld;
    end
  // holding buffer fill, and whole-pair load of both shifters at frame start
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      full <= 1'b0;
      buf_l <= '0;
      buf_r <= '0;
      sh_l <= '0;
      sh_r <= '0;
    end else if (frame) begin
      if (full) begin
        sh_l <= buf_l;
        sh_r <= buf_r;
        full <= 1'b0;
      end else if (bus.vld) begin
        sh_l <= bus.lft_in;
        sh_r <= bus.rht_in;
      end
    end else if (bus.vld && !full) begin
      buf_l <= bus.lft_in;
      buf_r <= bus.rht_in;
      full <= 1'b1;
    end
endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter: DATA_W, 24, sample width in bits per channel; legal range 16..30.
REQ-002 Port: clk  input  1  system clock, 50 MHz nominal; all logic on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: lft_in  input  DATA_W  left sample, two's complement.
REQ-005 Port: rht_in  input  DATA_W  right sample, two's complement.
REQ-006 Port: vld  input  1  lft_in/rht_in pair valid.
REQ-007 Port: rdy  output  1  holding buffer empty; pair accepted on a clk edge with vld&&rdy.
REQ-008 Port: MCLK  output  1  codec master clock, clk/4.
REQ-009 Port: SCLK  output  1  serial bit clock, clk/32.
REQ-010 Port: LRCLK  output  1  word select, clk/2048; 0 = left, 1 = right.
REQ-011 Port: SDout  output  1  I2S serial data to codec.
REQ-012 Port: underrun  output  1  one-clk pulse when a frame starts with no new pair.

Function
REQ-013 The block SHALL contain an 11-bit free-running counter cnt, incrementing every clk and wrapping 0x7FF->0x000.
REQ-014 Outputs SHALL be registered: MCLK = cnt[1], SCLK = cnt[4], LRCLK = cnt[10].
REQ-015 SCLK SHALL fall on the edge where cnt[4:0] becomes 0 and rise where it becomes 0x10; SDout SHALL change only on SCLK-falling edges.
REQ-016 Slot index SHALL be cnt[9:5] (0..31 per half-frame).
REQ-017 SDout SHALL be 0 in slot 0 and slots DATA_W+1..31; slot k (1..DATA_W) SHALL carry bit DATA_W-k (MSB in slot 1, one SCLK after the LRCLK edge).
REQ-018 The left shifter SHALL drive SDout while LRCLK=0 and the right shifter while LRCLK=1.
REQ-019 The block SHALL have a one-pair holding buffer with a full flag; rdy = ~full.
REQ-020 On vld&&rdy the pair SHALL be written to the buffer and full set on the same edge; vld while rdy=0 SHALL be ignored, and the buffer SHALL NOT be overwritten.
REQ-021 Frame start SHALL be the edge where cnt becomes 0x000.
REQ-022 At frame start with full=1, both shifters SHALL load from the buffer and full SHALL clear.
REQ-023 At frame start with full=0 and vld=1, the input pair SHALL bypass into the shifters; full SHALL stay 0, and underrun SHALL NOT pulse.
REQ-024 At frame start with full=0 and vld=0, the shifters SHALL retain the previous pair (retransmit), and underrun SHALL pulse for exactly 1 clk.
REQ-025 Left and right of one pair SHALL always be transmitted in the same frame; no pair is dropped or split.
REQ-026 Minimum latency from acceptance to MSB on SDout SHALL be 32 clks (bypass case: slot 1 starts at cnt=0x020).

Reset
REQ-027 While rst=1: cnt=0, MCLK=0, SCLK=0, LRCLK=0, SDout=0, underrun=0, full=0 (rdy=1), and shifters=0.
REQ-028 Assertion of rst mid-frame SHALL immediately abort the transfer and discard the buffered pair.
REQ-029 After rst deasserts, the first clk edge SHALL set cnt=1; the first frame start SHALL occur at cnt wrap, 2048 clks later.

Verification
REQ-030 Clock check: after reset, measure periods -> MCLK 4, SCLK 32, LRCLK 2048 clks; LRCLK toggles only coincident with SCLK falling.
REQ-031 Single pair: DATA_W=24, lft=0x800001, rht=0x7FFFFE, offered before frame start -> bench I2S decoder (sample SDout on SCLK rise) recovers both values exactly; SDout=0 in slots 0 and 25..31.
REQ-032 Underrun: one pair lft=0x123456, rht=0xFEDCBA, then vld=0 for 3 frames -> pair retransmitted 4 times; underrun pulses exactly 3 times, each 1 clk at cnt=0.
REQ-033 Bypass: hold vld=1 with full=0 exactly at frame-start cycle -> pair appears in that frame; rdy remains 1; no underrun.
REQ-034 Back-pressure: vld held high with a new pair every accepted cycle for 8 frames -> rdy high 1 clk per frame, 8 distinct pairs decoded in order, none lost.
REQ-035 Reset mid-frame: assert rst at slot 12 of the right half -> all outputs 0 within the same clk, rdy=1; next decoded pair is the first one offered after reset.
